// File: rtl/adc_frontend_cond.sv
// ADC input conditioner: code-format conversion, left-justification, optional DC removal,
// power-of-two gain with saturation, offset-binary DAC monitor word and held overrange flag.
module adc_frontend_cond #(
  parameter int ADC_W    = 12,
  parameter int OUT_W    = 16,
  parameter int DAC_W    = 14,
  parameter int DC_SHIFT = 10,
  parameter int OVR_HOLD = 4096
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [ADC_W-1:0] adc_data_in,
  input  logic             adc_fmt,
  input  logic             dc_en,
  input  logic [2:0]       gain_shift,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  output logic [DAC_W-1:0] dac_data_out,
  output logic [OUT_W-1:0] dc_est,
  output logic             ovr_flag
);

  localparam int ACC_W = OUT_W + DC_SHIFT;
  localparam int G_W   = OUT_W + 8;
  localparam int CNT_W = $clog2(OVR_HOLD + 1);

  localparam logic [ADC_W-1:0]      ADC_MAX = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [ADC_W-1:0]      ADC_MIN = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic signed [G_W-1:0] SAT_MAX = {{(G_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [G_W-1:0] SAT_MIN = {{(G_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [ADC_W-1:0] s1_reg;
  logic [OUT_W-1:0] s2_reg;
  logic [OUT_W:0]   d3_reg;
  logic             fs2_reg;
  logic             fs3_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [3:0]       valid_sr_reg;
  logic [CNT_W-1:0] ovr_cnt_reg;

  logic                  raw_fs;
  logic [ACC_W-1:0]      acc_next;
  logic [OUT_W:0]        s2_ext;
  logic [OUT_W:0]        dc_ext;
  logic [OUT_W:0]        d3_next;
  logic signed [G_W-1:0] g_wide;
  logic signed [G_W-1:0] g_sat;
  logic                  gain_sat;
  logic                  ovr_event;

  assign raw_fs = (s1_reg == ADC_MAX) || (s1_reg == ADC_MIN);

  // The upper OUT_W accumulator bits are exactly acc >>> DC_SHIFT truncated to OUT_W.
  assign dc_est   = acc_reg[ACC_W-1:DC_SHIFT];
  assign acc_next = acc_reg + {{DC_SHIFT{s2_reg[OUT_W-1]}}, s2_reg}
                            - {{DC_SHIFT{dc_est[OUT_W-1]}}, dc_est};

  assign s2_ext  = {s2_reg[OUT_W-1], s2_reg};
  assign dc_ext  = {dc_est[OUT_W-1], dc_est};
  assign d3_next = dc_en ? (s2_ext - dc_ext) : s2_ext;

  always_comb begin
    g_wide   = {{7{d3_reg[OUT_W]}}, d3_reg} <<< gain_shift;
    g_sat    = g_wide;
    gain_sat = 1'b0;
    if (g_wide > SAT_MAX) begin
      g_sat    = SAT_MAX;
      gain_sat = 1'b1;
    end else if (g_wide < SAT_MIN) begin
      g_sat    = SAT_MIN;
      gain_sat = 1'b1;
    end
  end

  assign ovr_event  = fs3_reg || gain_sat;
  assign ovr_flag   = (ovr_cnt_reg != '0);
  assign data_valid = valid_sr_reg[3];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      d3_reg       <= '0;
      fs2_reg      <= 1'b0;
      fs3_reg      <= 1'b0;
      acc_reg      <= '0;
      valid_sr_reg <= '0;
      ovr_cnt_reg  <= '0;
      data_out     <= '0;
      dac_data_out <= {1'b1, {(DAC_W-1){1'b0}}};
    end else begin
      s1_reg       <= {adc_data_in[ADC_W-1] ^ ~adc_fmt, adc_data_in[ADC_W-2:0]};
      s2_reg       <= {s1_reg, {(OUT_W-ADC_W){1'b0}}};
      fs2_reg      <= raw_fs;
      d3_reg       <= d3_next;
      fs3_reg      <= fs2_reg;
      acc_reg      <= acc_next;
      valid_sr_reg <= {valid_sr_reg[2:0], 1'b1};
      data_out     <= g_sat[OUT_W-1:0];
      dac_data_out <= {~g_sat[OUT_W-1], g_sat[OUT_W-2 -: DAC_W-1]};
      // Retriggerable hold: any event reloads, otherwise count down and stick at zero.
      if (ovr_event) begin
        ovr_cnt_reg <= CNT_W'(OVR_HOLD);
      end else if (ovr_cnt_reg != '0) begin
        ovr_cnt_reg <= ovr_cnt_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_frontend_cond.sv
// Self-checking bench for adc_frontend_cond: directed vector table, overrange hold,
// DC-removal decay with mid-run reset, and randomized stimulus against an arithmetic model.
module tb_adc_frontend_cond;

  localparam int NV   = 12;
  localparam int NRND = 600;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [11:0] adc_data_in = '0;
  logic        adc_fmt = 1'b0;
  logic        dc_en = 1'b0;
  logic [2:0]  gain_shift = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [13:0] dac_data_out;
  logic [15:0] dc_est;
  logic        ovr_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] adc;
    logic        fmt;
    logic [2:0]  gs;
    logic [15:0] out;
    logic [13:0] dac;
    logic        ovr;
  } vec_t;

  vec_t tv [NV];

  adc_frontend_cond dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .adc_data_in  (adc_data_in),
    .adc_fmt      (adc_fmt),
    .dc_en        (dc_en),
    .gain_shift   (gain_shift),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .dac_data_out (dac_data_out),
    .dc_est       (dc_est),
    .ovr_flag     (ovr_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint v, input longint d);
    floor_div = (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  // Signed sample value of a raw code under the selected format.
  function automatic int adc_value(input int code, input bit fmt);
    if (!fmt) adc_value = code - 2048;
    else      adc_value = (code >= 2048) ? code - 4096 : code;
  endfunction

  int x_hist  [0:NRND];
  int d3_hist [0:NRND];
  bit fs_hist [0:NRND];

  initial begin
    int prev;
    longint acc;
    int last_ev;

    tv[0]  = '{12'h800, 1'b0, 3'd0, 16'h0000, 14'h2000, 1'b0};
    tv[1]  = '{12'hFFF, 1'b0, 3'd0, 16'h7FF0, 14'h3FFC, 1'b1};
    tv[2]  = '{12'h100, 1'b1, 3'd0, 16'h1000, 14'h2400, 1'b0};
    tv[3]  = '{12'hF00, 1'b1, 3'd0, 16'hF000, 14'h1C00, 1'b0};
    tv[4]  = '{12'h200, 1'b1, 3'd3, 16'h7FFF, 14'h3FFF, 1'b1};
    tv[5]  = '{12'hE00, 1'b1, 3'd3, 16'h8000, 14'h0000, 1'b1};
    tv[6]  = '{12'h000, 1'b0, 3'd0, 16'h8000, 14'h0000, 1'b1};
    tv[7]  = '{12'h7FF, 1'b1, 3'd0, 16'h7FF0, 14'h3FFC, 1'b1};
    tv[8]  = '{12'h001, 1'b1, 3'd7, 16'h0800, 14'h2200, 1'b0};
    tv[9]  = '{12'h0FF, 1'b1, 3'd7, 16'h7FFF, 14'h3FFF, 1'b1};
    tv[10] = '{12'hFFF, 1'b1, 3'd7, 16'hF800, 14'h1E00, 1'b0};
    tv[11] = '{12'h801, 1'b0, 3'd2, 16'h0040, 14'h2010, 1'b0};

    // Reset state
    sys_rst = 1'b1;
    tick(); tick();
    check("rst_data_out", data_out, 16'h0000);
    check("rst_dac", dac_data_out, 14'h2000);
    check("rst_ovr", ovr_flag, 0);
    check("rst_valid", data_valid, 0);
    check("rst_dc_est", dc_est, 16'h0000);
    $display("reset: data_out=%h dac=%h ovr=%0d valid=%0d", data_out, dac_data_out, ovr_flag, data_valid);

    // Directed vectors: each from a fresh reset, checked at the 3rd and 4th edge.
    for (int i = 0; i < NV; i++) begin
      sys_rst = 1'b1;
      tick();
      adc_data_in = tv[i].adc;
      adc_fmt     = tv[i].fmt;
      gain_shift  = tv[i].gs;
      dc_en       = 1'b0;
      sys_rst     = 1'b0;
      tick(); tick(); tick();
      check("vec_early_out", data_out, 16'h0000);
      check("vec_early_valid", data_valid, 0);
      check("vec_early_ovr", ovr_flag, 0);
      tick();
      check("vec_data_out", data_out, tv[i].out);
      check("vec_dac", dac_data_out, tv[i].dac);
      check("vec_ovr", ovr_flag, tv[i].ovr);
      check("vec_valid", data_valid, 1);
      $display("vec %0d: adc=%h fmt=%0d gs=%0d -> data_out=%h dac=%h ovr=%0d",
               i, tv[i].adc, tv[i].fmt, tv[i].gs, data_out, dac_data_out, ovr_flag);
    end

    // Overrange hold after one saturating sample.
    sys_rst = 1'b1;
    tick();
    adc_fmt = 1'b1; dc_en = 1'b0; gain_shift = 3'd3; adc_data_in = 12'h200;
    sys_rst = 1'b0;
    tick();
    adc_data_in = 12'h000;
    tick(); tick(); tick();
    check("hold_sat_out", data_out, 16'h7FFF);
    check("hold_first", ovr_flag, 1);
    repeat (4095) tick();
    check("hold_last", ovr_flag, 1);
    tick();
    check("hold_drop", ovr_flag, 0);
    check("hold_zero_out", data_out, 16'h0000);
    $display("ovr hold: dropped after 4096 cycles, ovr=%0d", ovr_flag);

    // DC removal with constant input, mid-run reset, then long convergence.
    sys_rst = 1'b1;
    tick();
    adc_fmt = 1'b1; dc_en = 1'b1; gain_shift = 3'd0; adc_data_in = 12'h100;
    sys_rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("dc_start", data_out, 16'h1000);
    prev = 32'sh1000;
    for (int k = 0; k < 2000; k++) begin
      tick();
      check("dc_monotone", int'($signed(data_out)) <= prev, 1);
      prev = int'($signed(data_out));
    end
    $display("dc decay: after 2000 cycles data_out=%h dc_est=%h", data_out, dc_est);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("mid_rst_dc_est", dc_est, 16'h0000);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_out", data_out, 16'h0000);
    tick(); tick(); tick();
    check("mid_rst_valid3", data_valid, 0);
    tick();
    check("mid_rst_valid4", data_valid, 1);
    check("mid_rst_restart", data_out, 16'h1000);
    repeat (16384) tick();
    prev = int'($signed(data_out));
    check("dc_final_out", (prev <= 16) && (prev >= -16), 1);
    check("dc_final_est", (int'(dc_est) >= 16'h0FF0) && (int'(dc_est) <= 16'h1010), 1);
    $display("dc converged: data_out=%h dc_est=%h", data_out, dc_est);

    // Randomized stimulus against the arithmetic model.
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    acc = 0;
    last_ev = -100000;
    for (int e = 1; e <= NRND; e++) begin
      int a, sv, xm2, d3m1, g, outv, dcv;
      bit f, den, sat, ev;
      int gs;
      a = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 31) == 0) a = (a[0]) ? 12'h7FF : 12'hFFF;
      f   = 1'($urandom_range(0, 1));
      den = 1'($urandom_range(0, 1));
      gs  = (e > NRND / 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      adc_data_in = 12'(a); adc_fmt = f; dc_en = den; gain_shift = 3'(gs);
      tick();

      sv          = adc_value(a, f);
      x_hist[e]   = sv * 16;
      fs_hist[e]  = (sv == 2047) || (sv == -2048);
      xm2         = (e >= 3) ? x_hist[e-2] : 0;
      dcv         = int'(floor_div(acc, 1024));
      d3_hist[e]  = den ? xm2 - dcv : xm2;
      acc         = acc + xm2 - dcv;
      d3m1        = (e >= 2) ? d3_hist[e-1] : 0;
      g           = d3m1 * (1 << gs);
      sat         = (g > 32767) || (g < -32768);
      outv        = (g > 32767) ? 32767 : (g < -32768) ? -32768 : g;
      ev          = sat || (e >= 4 && fs_hist[e-3]);
      if (ev) last_ev = e;

      check("rnd_data_out", data_out, outv & 16'hFFFF);
      check("rnd_dac", dac_data_out, (floor_div(outv, 4) + 8192) & 14'h3FFF);
      check("rnd_dc_est", dc_est, floor_div(acc, 1024) & 16'hFFFF);
      check("rnd_ovr", ovr_flag, ((e - last_ev) < 4096) ? 1 : 0);
      check("rnd_valid", data_valid, (e >= 4) ? 1 : 0);
    end
    $display("random: %0d samples compared against model", NRND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
